clock_divider_bank: RTL

Parametrised divided-clock and enable generator for the DRAM/logic clock domain. It runs on `int_double_drm_clock_buffered` and produces NUM_CHANNELS independently programmable divided clocks, each with aligned last-cycle enables; the divided clocks feed external BUFGs. It also sequences `system_reset_out` from synchronised DCM lock inputs with a stability window. Divide ratio and high time are reprogrammable at run time, glitch-free at period boundaries.

---
 rtl/clock_divider_pkg.sv | 28 ++
 rtl/clock_divider_channel.sv | 115 +++++++++++
 rtl/clock_divider_bank.sv | 89 ++++++++
 3 files changed

// File: rtl/clock_divider_pkg.sv
// ============================================================================
// clock_divider_pkg : shared defaults and the effective high-time rule
// Revision: 1.0
// ============================================================================
`default_nettype none

package clock_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 5;
  localparam int DIV_WIDTH_MAX     = 16;

  // Out-of-range high times fall back to a ~50% duty cycle for the ratio.
  function automatic logic [DIV_WIDTH_MAX-1:0] high_eff(
    input logic [DIV_WIDTH_MAX-1:0] ratio,
    input logic [DIV_WIDTH_MAX-1:0] high
  );
    logic [DIV_WIDTH_MAX:0] period;
    period = {1'b0, ratio} + {{DIV_WIDTH_MAX{1'b0}}, 1'b1};
    if ((high != '0) && (high <= ratio)) begin
      high_eff = high;
    end else begin
      high_eff = period[DIV_WIDTH_MAX:1];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_divider_channel.sv
// ============================================================================
// clock_divider_channel : one divider with shadow config applied at wrap
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 int_double_drm_clock_buffered,
  input  logic                 system_reset_in,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  input  logic [DIV_WIDTH-1:0] div_high,
  input  logic                 cfg_load,
  input  logic                 sync_all,
  output logic                 cfg_ack,
  output logic                 clk_out,
  output logic                 cke_last,
  output logic                 cke_next_last
);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] ratio_q, ratio_d;
  logic [DIV_WIDTH-1:0] high_q, high_d;
  logic [DIV_WIDTH-1:0] shadow_ratio_q, shadow_ratio_d;
  logic [DIV_WIDTH-1:0] shadow_high_q, shadow_high_d;
  logic                 pending_q, pending_d;
  logic                 cfg_ack_q, cfg_ack_d;
  logic                 clk_out_q, clk_out_d;
  logic                 cke_last_q, cke_last_d;
  logic                 cke_next_last_q, cke_next_last_d;

  logic                 wrap;
  logic                 running;
  logic [DIV_WIDTH-1:0] high_eff_d;

  always_comb begin
    wrap           = (count_q == ratio_q);
    ratio_d        = ratio_q;
    high_d         = high_q;
    shadow_ratio_d = shadow_ratio_q;
    shadow_high_d  = shadow_high_q;
    pending_d      = pending_q;
    cfg_ack_d      = 1'b0;
    count_d        = wrap ? '0 : count_q + 1'b1;

    if (sync_all) begin
      count_d   = '0;
      pending_d = 1'b0;
      cfg_ack_d = pending_q | cfg_load;
      if (cfg_load) begin
        ratio_d = div_ratio;
        high_d  = div_high;
      end else if (pending_q) begin
        ratio_d = shadow_ratio_q;
        high_d  = shadow_high_q;
      end
    end else if (pending_q && wrap) begin
      ratio_d   = shadow_ratio_q;
      high_d    = shadow_high_q;
      cfg_ack_d = 1'b1;
      pending_d = 1'b0;
    end

    // A load coinciding with a wrap-apply stays pending for the next period.
    if (cfg_load) begin
      shadow_ratio_d = div_ratio;
      shadow_high_d  = div_high;
      pending_d      = !sync_all;
    end

    // Outputs are computed from next-state counter so they align with it.
    high_eff_d      = DIV_WIDTH'(high_eff(DIV_WIDTH_MAX'(ratio_d), DIV_WIDTH_MAX'(high_d)));
    running         = (ratio_d != '0);
    clk_out_d       = running && (count_d < high_eff_d);
    cke_last_d      = running && (count_d == ratio_d);
    cke_next_last_d = running && (count_d == ratio_d - 1'b1);
  end

  always_ff @(posedge int_double_drm_clock_buffered or posedge system_reset_in) begin
    if (system_reset_in) begin
      count_q         <= '0;
      ratio_q         <= '0;
      high_q          <= '0;
      shadow_ratio_q  <= '0;
      shadow_high_q   <= '0;
      pending_q       <= 1'b0;
      cfg_ack_q       <= 1'b0;
      clk_out_q       <= 1'b0;
      cke_last_q      <= 1'b0;
      cke_next_last_q <= 1'b0;
    end else begin
      count_q         <= count_d;
      ratio_q         <= ratio_d;
      high_q          <= high_d;
      shadow_ratio_q  <= shadow_ratio_d;
      shadow_high_q   <= shadow_high_d;
      pending_q       <= pending_d;
      cfg_ack_q       <= cfg_ack_d;
      clk_out_q       <= clk_out_d;
      cke_last_q      <= cke_last_d;
      cke_next_last_q <= cke_next_last_d;
    end
  end

  assign cfg_ack       = cfg_ack_q;
  assign clk_out       = clk_out_q;
  assign cke_last      = cke_last_q;
  assign cke_next_last = cke_next_last_q;

endmodule

`default_nettype wire

// File: rtl/clock_divider_bank.sv
// ============================================================================
// clock_divider_bank : divided clocks, period enables and DCM reset sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int NUM_CHANNELS       = 2,
  parameter int DIV_WIDTH          = DIV_WIDTH_DEFAULT,
  parameter int NUM_LOCKS          = 2,
  parameter int LOCK_STABLE_CYCLES = 64
) (
  input  logic                              int_double_drm_clock_buffered,
  input  logic                              system_reset_in,
  input  logic [NUM_LOCKS-1:0]              dcm_locked,
  input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] div_ratio,
  input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] div_high,
  input  logic [NUM_CHANNELS-1:0]           cfg_load,
  output logic [NUM_CHANNELS-1:0]           cfg_ack,
  input  logic                              sync_all,
  output logic [NUM_CHANNELS-1:0]           clk_out,
  output logic [NUM_CHANNELS-1:0]           cke_last,
  output logic [NUM_CHANNELS-1:0]           cke_next_last,
  output logic [NUM_LOCKS-1:0]              locked_status,
  output logic                              system_reset_out
);

  localparam int                  STABLE_W     = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [STABLE_W-1:0] STABLE_LIMIT = STABLE_W'(LOCK_STABLE_CYCLES);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
    clock_divider_channel #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_channel (
      .int_double_drm_clock_buffered (int_double_drm_clock_buffered),
      .system_reset_in               (system_reset_in),
      .div_ratio                     (div_ratio[i*DIV_WIDTH +: DIV_WIDTH]),
      .div_high                      (div_high[i*DIV_WIDTH +: DIV_WIDTH]),
      .cfg_load                      (cfg_load[i]),
      .sync_all                      (sync_all),
      .cfg_ack                       (cfg_ack[i]),
      .clk_out                       (clk_out[i]),
      .cke_last                      (cke_last[i]),
      .cke_next_last                 (cke_next_last[i])
    );
  end

  logic [NUM_LOCKS-1:0] lock_meta_q, lock_meta_d;
  logic [NUM_LOCKS-1:0] lock_sync_q, lock_sync_d;
  logic [STABLE_W-1:0]  stable_count_q, stable_count_d;
  logic                 system_reset_out_q, system_reset_out_d;
  logic                 all_locked;

  always_comb begin
    lock_meta_d    = dcm_locked;
    lock_sync_d    = lock_meta_q;
    all_locked     = &lock_sync_q;
    stable_count_d = stable_count_q;
    if (!all_locked) begin
      stable_count_d = '0;
    end else if (stable_count_q != STABLE_LIMIT) begin
      stable_count_d = stable_count_q + 1'b1;
    end
    // A single low synchronised lock reasserts reset on the very next edge.
    system_reset_out_d = !(all_locked && (stable_count_q == STABLE_LIMIT));
  end

  always_ff @(posedge int_double_drm_clock_buffered or posedge system_reset_in) begin
    if (system_reset_in) begin
      lock_meta_q        <= '0;
      lock_sync_q        <= '0;
      stable_count_q     <= '0;
      system_reset_out_q <= 1'b1;
    end else begin
      lock_meta_q        <= lock_meta_d;
      lock_sync_q        <= lock_sync_d;
      stable_count_q     <= stable_count_d;
      system_reset_out_q <= system_reset_out_d;
    end
  end

  assign locked_status    = lock_sync_q;
  assign system_reset_out = system_reset_out_q;

endmodule

`default_nettype wire
